uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
Downstream consumer of the UART byte receiver. Takes each received byte and its one-cycle strobe, and assembles fixed 5-byte command frames: SYNC, ADDR, DATA_HI, DATA_LO, CSUM. Validates the checksum and presents a register-write request (8-bit address, 16-bit data) to the control core, with a one-cycle strobe per good frame.

Parameters:
SYNC_BYTE, 8'hAA, frame start marker.
TIMEOUT_CYCLES, 42700, maximum clk cycles between bytes inside a frame (about 10 byte times at 115200 baud on a 49.2 MHz clk).
CNT_W, 16, width of the inter-byte timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
rx_data  input  8  byte from the UART receiver; valid only while rx_strobe=1.
rx_strobe  input  1  one-cycle pulse, byte available.
wr_addr  output  8  address of the last good frame.
wr_data  output  16  data of the last good frame, {DATA_HI, DATA_LO}.
wr_strobe  output  1  one-cycle pulse, good frame latched.
csum_err  output  1  one-cycle pulse, checksum mismatch.
timeout_err  output  1  one-cycle pulse, frame abandoned by timeout.
busy  output  1  high while a frame is in progress (state != S_SYNC).

Behaviour:
- Reset (async, rst=1): state=S_SYNC; wr_addr=0, wr_data=0; all pulses=0; busy=0; accumulators and counter=0. A reset mid-frame discards the partial frame with no error pulse.
- States: S_SYNC -> S_ADDR -> S_DHI -> S_DLO -> S_CSUM -> S_SYNC. Each transition happens only on a clock edge where rx_strobe=1.
- S_SYNC:
  - rx_data==SYNC_BYTE moves to S_ADDR.
  - Any other byte is silently ignored.
- S_ADDR, S_DHI, S_DLO: capture the byte into shadow registers.
- Running sum: sum = (ADDR + DATA_HI + DATA_LO) mod 256, 8-bit wrap-around, no carry kept.
- SYNC_BYTE seen inside a frame is treated as data. There is no resync mid-frame.
- S_CSUM byte arrives:
  - Match (rx_data==sum): on the next edge, wr_addr and wr_data are loaded from the shadow registers and wr_strobe=1 for exactly one cycle.
  - Mismatch: csum_err=1 for one cycle and outputs are unchanged.
  - Either way, return to S_SYNC.
- Latency: wr_strobe and csum_err rise on the clock edge that samples the CSUM byte's rx_strobe, i.e. they are registered and visible one cycle after the strobe.
- wr_addr/wr_data hold their value until the next good frame. They change only in the same cycle that wr_strobe rises.
- wr_strobe and csum_err are mutually exclusive.
- Back-to-back rx_strobe on consecutive cycles must be accepted with no byte lost. A new frame's SYNC may arrive the cycle right after CSUM.
- busy=1 from the edge after SYNC acceptance until the edge that returns the parser to S_SYNC.

Optional Feature:
Macro: UART_FRAME_TIMEOUT_EN.
- Defined:
  - The counter clears on every rx_strobe and on entry to S_SYNC.
  - It increments each cycle while state != S_SYNC.
  - When it reaches TIMEOUT_CYCLES, the parser returns to S_SYNC, timeout_err=1 for one cycle, and the partial frame is discarded.
  - If rx_strobe coincides with the terminal count, the byte wins: the counter clears and there is no timeout.
  - The counter saturates and does not wrap.
- Not defined: no counter is present; timeout_err is tied to 0 and a partial frame waits indefinitely.

Test Plan:
1. Good frame: bytes AA 12 34 56 9C, spaced 4270 cycles apart -> one wr_strobe; wr_addr=8'h12, wr_data=16'h3456; csum_err=0; busy falls with the strobe.
2. Bad checksum: AA 12 34 56 9D -> csum_err pulse, no wr_strobe; wr_addr/wr_data keep the prior 12/3456.
3. Garbage then frame, with wrap-around: 00 FF 55 AA 80 C0 C1 01 -> garbage ignored; wr_addr=8'h80, wr_data=16'hC0C1 (sum 0x201 mod 256 = 0x01).
4. Back-to-back: two frames AA 01 00 02 03 and AA AA AA AA 7E on 10 consecutive cycles of rx_strobe -> two wr_strobes, the second giving wr_addr=AA, wr_data=AAAA (0x1FE mod 256 = 0xFE ≠ 7E, so expect csum_err instead); then repeat with CSUM=FE -> wr_strobe.
5. Timeout (macro on): AA 12, then idle for 42700 cycles -> timeout_err, busy=0; then frame 1 -> accepted. With the strobe at exactly terminal count -> no timeout. With the macro off, the same stimulus leaves busy=1 and timeout_err=0.
6. Reset mid-frame: AA 12 34, assert rst for 3 cycles, then AA 05 00 07 0C -> all outputs 0 during reset, no error pulses; wr_addr=05, wr_data=0007.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// -----------------------------------------------------------------------------
// Purpose: sits behind the UART byte receiver. It builds fixed 5-byte command
// frames (SYNC, ADDR, DATA_HI, DATA_LO, CSUM) and checks the 8-bit wrap-around
// checksum. For each good frame it presents a register-write request (address
// and data) with a one-cycle strobe.
//
// Optional feature macro: UART_FRAME_TIMEOUT_EN
//   If defined, an inter-byte watchdog abandons a partial frame after
//   TIMEOUT_CYCLES idle clocks and pulses timeout_err.
//   If undefined, no counter is built, timeout_err is tied low, and a partial
//   frame waits indefinitely.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   rx_data[7:0] received byte, valid while rx_strobe=1
//   rx_strobe    one-cycle byte-available pulse
//   wr_addr[7:0] address of the last good frame
//   wr_data[15:0] data of the last good frame, {DATA_HI, DATA_LO}
//   wr_strobe    one-cycle pulse, good frame latched into wr_addr/wr_data
//   csum_err     one-cycle pulse, checksum mismatch (outputs left unchanged)
//   timeout_err  one-cycle pulse, partial frame abandoned by the watchdog
//   busy         high while a frame is in progress (state != S_SYNC)
//
// Handshake: rx_strobe is a qualifier-only strobe with no back-pressure. A byte
// is consumed on every rising edge where rx_strobe=1, including consecutive
// cycles. wr_strobe, csum_err and timeout_err are registered single-cycle
// pulses and are mutually exclusive.
// -----------------------------------------------------------------------------
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 42700,
  parameter int         CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_strobe,
  output logic        csum_err,
  output logic        timeout_err,
  output logic        busy
);

  // The watchdog counter must be able to represent the terminal count.
  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("uart_frame_parser: CNT_W too small for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [7:0]  addr_q, addr_n;
  logic [7:0]  dhi_q, dhi_n;
  logic [7:0]  dlo_q, dlo_n;
  logic [7:0]  sum_q, sum_n;
  logic        good_n, cerr_n, terr_n;
  logic        timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // An arriving byte always beats the terminal count.
  assign timeout_hit = (state != S_SYNC) && !rx_strobe && (cnt_q == TERM_CNT);

  // The counter is held at zero while idle in S_SYNC, so it is always zero on
  // entry to a new frame. It saturates at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (rx_strobe || state == S_SYNC) begin
      cnt_q <= '0;
    end else if (cnt_q != TERM_CNT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, shadow-capture and pulse logic.
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    dhi_n   = dhi_q;
    dlo_n   = dlo_q;
    sum_n   = sum_q;
    good_n  = 1'b0;
    cerr_n  = 1'b0;
    terr_n  = 1'b0;
    if (timeout_hit) begin
      state_n = S_SYNC;
      terr_n  = 1'b1;
    end else if (rx_strobe) begin
      case (state)
        S_SYNC: begin
          if (rx_data == SYNC_BYTE) begin
            state_n = S_ADDR;
            sum_n   = 8'h00;
          end
        end
        S_ADDR: begin
          addr_n  = rx_data;
          sum_n   = rx_data;
          state_n = S_DHI;
        end
        S_DHI: begin
          dhi_n   = rx_data;
          sum_n   = sum_q + rx_data;
          state_n = S_DLO;
        end
        S_DLO: begin
          dlo_n   = rx_data;
          sum_n   = sum_q + rx_data;
          state_n = S_CSUM;
        end
        S_CSUM: begin
          if (rx_data == sum_q) begin
            good_n = 1'b1;
          end else begin
            cerr_n = 1'b1;
          end
          state_n = S_SYNC;
        end
        default: begin
          state_n = S_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_SYNC;
      addr_q      <= 8'h00;
      dhi_q       <= 8'h00;
      dlo_q       <= 8'h00;
      sum_q       <= 8'h00;
      wr_addr     <= 8'h00;
      wr_data     <= 16'h0000;
      wr_strobe   <= 1'b0;
      csum_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      dhi_q       <= dhi_n;
      dlo_q       <= dlo_n;
      sum_q       <= sum_n;
      wr_strobe   <= good_n;
      csum_err    <= cerr_n;
      timeout_err <= terr_n;
      // The request registers move only together with wr_strobe.
      if (good_n) begin
        wr_addr <= addr_q;
        wr_data <= {dhi_q, dlo_q};
      end
    end
  end

  assign busy = (state != S_SYNC);

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
// -----------------------------------------------------------------------------
// Purpose: self-checking bench for uart_frame_parser. Frames are driven byte by
// byte. The expected outcome of each frame (good write, checksum error or
// watchdog timeout) goes into a scoreboard queue when the frame's stimulus is
// driven, and a negedge monitor pops and compares it when the DUT pulses.
// Scenario tasks also make inline comparisons of busy and the output registers.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_CYC = 5000;
`else
  localparam int TO_CYC = 42700;
`endif
  localparam int W = 26;  // {kind[1:0], addr[7:0], data[15:0]}
  localparam logic [1:0] K_GOOD = 2'd1;
  localparam logic [1:0] K_CERR = 2'd2;
  localparam logic [1:0] K_TERR = 2'd3;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_strobe;
  logic        csum_err;
  logic        timeout_err;
  logic        busy;

  logic [W-1:0] exp_q[$];
  int pass_cnt;
  int total_cnt;

  uart_frame_parser #(
    .SYNC_BYTE      (8'hAA),
    .TIMEOUT_CYCLES (TO_CYC),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_strobe   (rx_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_strobe   (wr_strobe),
    .csum_err    (csum_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor and scoreboard: every pulse must match the head of exp_q, and the
  // request registers may only move in a wr_strobe cycle.
  logic [23:0]  prev_req;
  logic [W-1:0] exp_e;
  logic [1:0]   obs_kind;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = {wr_addr, wr_data};
    end else begin
      total_cnt++;
      if ((wr_strobe + csum_err + timeout_err) > 1) begin
        $display("FAIL pulse_exclusive: wr_strobe=%0b csum_err=%0b timeout_err=%0b, required at most one",
                 wr_strobe, csum_err, timeout_err);
      end else begin
        pass_cnt++;
      end
      if (wr_strobe || csum_err || timeout_err) begin
        obs_kind = wr_strobe ? K_GOOD : (csum_err ? K_CERR : K_TERR);
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pulse: kind=%0d at %0t, required no pulse", obs_kind, $time);
        end else begin
          exp_e = exp_q.pop_front();
          if (exp_e[25:24] !== obs_kind) begin
            $display("FAIL pulse_kind: got kind=%0d, required kind=%0d", obs_kind, exp_e[25:24]);
          end else if (obs_kind == K_GOOD && {wr_addr, wr_data} !== exp_e[23:0]) begin
            $display("FAIL wr_request: got addr=%h data=%h, required addr=%h data=%h",
                     wr_addr, wr_data, exp_e[23:16], exp_e[15:0]);
          end else begin
            pass_cnt++;
          end
        end
      end
      total_cnt++;
      if (!wr_strobe && {wr_addr, wr_data} !== prev_req) begin
        $display("FAIL req_hold: addr/data changed to %h/%h without wr_strobe, required %h/%h",
                 wr_addr, wr_data, prev_req[23:16], prev_req[15:0]);
      end else begin
        pass_cnt++;
      end
      prev_req = {wr_addr, wr_data};
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(posedge clk);
    #1;
    rx_strobe = 1'b0;
    rx_data   = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends SYNC + 4 bytes with `gap` idle cycles between bytes. The expected
  // outcome is pushed before the CSUM byte is driven.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c,
                            input int gap);
    logic [7:0] s;
    s = a + h + l;
    send_byte(8'hAA);
    if (gap > 0) idle(gap);
    send_byte(a);
    if (gap > 0) idle(gap);
    send_byte(h);
    if (gap > 0) idle(gap);
    send_byte(l);
    if (gap > 0) idle(gap);
    if (c == s) exp_q.push_back({K_GOOD, a, h, l});
    else        exp_q.push_back({K_CERR, 24'h0});
    send_byte(c);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    rx_strobe = 1'b0;
    rx_data   = 8'h00;
    idle(3);
    total_cnt++;
    if ({wr_addr, wr_data, wr_strobe, csum_err, timeout_err, busy} !== 28'h0) begin
      $display("FAIL reset_state: addr=%h data=%h ws=%b ce=%b te=%b busy=%b, required all 0",
               wr_addr, wr_data, wr_strobe, csum_err, timeout_err, busy);
    end else pass_cnt++;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    send_byte(8'hAA);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL good_busy_rise: busy=%b, required 1", busy);
    else pass_cnt++;
    idle(4270);
    send_byte(8'h12); idle(4270);
    send_byte(8'h34); idle(4270);
    send_byte(8'h56); idle(4270);
    exp_q.push_back({K_GOOD, 8'h12, 16'h3456});
    send_byte(8'h9C);
    total_cnt++;
    if ({wr_strobe, busy, csum_err, wr_addr, wr_data} !== {3'b100, 8'h12, 16'h3456}) begin
      $display("FAIL good_frame: ws=%b busy=%b ce=%b addr=%h data=%h, required ws=1 busy=0 ce=0 12/3456",
               wr_strobe, busy, csum_err, wr_addr, wr_data);
    end else pass_cnt++;
    idle(3);
  endtask

  task automatic test_bad_csum();
    send_frame(8'h12, 8'h34, 8'h56, 8'h9D, 0);
    total_cnt++;
    if ({csum_err, wr_strobe, busy} !== 3'b100) begin
      $display("FAIL bad_csum_pulse: ce=%b ws=%b busy=%b, required ce=1 ws=0 busy=0",
               csum_err, wr_strobe, busy);
    end else pass_cnt++;
    idle(2);
    total_cnt++;
    if ({wr_addr, wr_data} !== {8'h12, 16'h3456}) begin
      $display("FAIL bad_csum_hold: addr=%h data=%h, required 12/3456", wr_addr, wr_data);
    end else pass_cnt++;
  endtask

  task automatic test_garbage_wrap();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h55);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL garbage_busy: busy=%b, required 0", busy);
    else pass_cnt++;
    send_frame(8'h80, 8'hC0, 8'hC1, 8'h01, 0);
    total_cnt++;
    if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 8'h80, 16'hC0C1}) begin
      $display("FAIL garbage_wrap: ws=%b addr=%h data=%h, required ws=1 80/C0C1",
               wr_strobe, wr_addr, wr_data);
    end else pass_cnt++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h01, 8'h00, 8'h02, 8'h03, 0);
    send_frame(8'hAA, 8'hAA, 8'hAA, 8'h7E, 0);
    total_cnt++;
    if ({csum_err, wr_addr, wr_data} !== {1'b1, 8'h01, 16'h0002}) begin
      $display("FAIL b2b_sync_as_data: ce=%b addr=%h data=%h, required ce=1 01/0002",
               csum_err, wr_addr, wr_data);
    end else pass_cnt++;
    send_frame(8'hAA, 8'hAA, 8'hAA, 8'hFE, 0);
    total_cnt++;
    if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 8'hAA, 16'hAAAA}) begin
      $display("FAIL b2b_second: ws=%b addr=%h data=%h, required ws=1 AA/AAAA",
               wr_strobe, wr_addr, wr_data);
    end else pass_cnt++;
    idle(2);
  endtask

  task automatic test_timeout();
    send_byte(8'hAA);
    send_byte(8'h12);
`ifdef UART_FRAME_TIMEOUT_EN
    idle(TO_CYC);  // counter now sits at the terminal count
    total_cnt++;
    if ({timeout_err, busy} !== 2'b01) begin
      $display("FAIL timeout_early: te=%b busy=%b, required te=0 busy=1", timeout_err, busy);
    end else pass_cnt++;
    exp_q.push_back({K_TERR, 24'h0});
    idle(1);
    total_cnt++;
    if ({timeout_err, busy} !== 2'b10) begin
      $display("FAIL timeout_fire: te=%b busy=%b, required te=1 busy=0", timeout_err, busy);
    end else pass_cnt++;
    idle(2);
    send_frame(8'h12, 8'h34, 8'h56, 8'h9C, 0);
    idle(2);
    // Byte arrives exactly at the terminal count: the byte wins.
    send_byte(8'hAA);
    send_byte(8'h12);
    idle(TO_CYC);
    send_byte(8'h34);
    total_cnt++;
    if ({timeout_err, busy} !== 2'b01) begin
      $display("FAIL timeout_terminal: te=%b busy=%b, required te=0 busy=1", timeout_err, busy);
    end else pass_cnt++;
    send_byte(8'h56);
    exp_q.push_back({K_GOOD, 8'h12, 16'h3456});
    send_byte(8'h9C);
`else
    idle(TO_CYC + 2);
    total_cnt++;
    if ({timeout_err, busy} !== 2'b01) begin
      $display("FAIL no_timeout: te=%b busy=%b, required te=0 busy=1", timeout_err, busy);
    end else pass_cnt++;
    send_byte(8'h34);
    send_byte(8'h56);
    exp_q.push_back({K_GOOD, 8'h12, 16'h3456});
    send_byte(8'h9C);
`endif
    total_cnt++;
    if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 8'h12, 16'h3456}) begin
      $display("FAIL timeout_resume: ws=%b addr=%h data=%h, required ws=1 12/3456",
               wr_strobe, wr_addr, wr_data);
    end else pass_cnt++;
    idle(2);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hAA);
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({wr_addr, wr_data, wr_strobe, csum_err, timeout_err, busy} !== 28'h0) begin
        $display("FAIL reset_mid: cycle %0d addr=%h data=%h ws=%b ce=%b te=%b busy=%b, required all 0",
                 i, wr_addr, wr_data, wr_strobe, csum_err, timeout_err, busy);
      end else pass_cnt++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle(1);
    send_frame(8'h05, 8'h00, 8'h07, 8'h0C, 0);
    total_cnt++;
    if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 8'h05, 16'h0007}) begin
      $display("FAIL reset_resume: ws=%b addr=%h data=%h, required ws=1 05/0007",
               wr_strobe, wr_addr, wr_data);
    end else pass_cnt++;
    idle(3);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_garbage_wrap();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expected pulses never seen, required 0", exp_q.size());
    end else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
